// File: rtl/pcs_hdr_err_inject_if.sv
`default_nettype none
// ============================================================================
// pcs_hdr_err_inject_if : SERDES block/sync-header bundle between PCS TX and RX
// Rev 1.0
// ============================================================================
interface pcs_hdr_err_inject_if #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2
);
  logic [DATA_WIDTH-1:0] serdes_tx_data;
  logic [HDR_WIDTH-1:0]  serdes_tx_hdr;
  logic [DATA_WIDTH-1:0] serdes_rx_data;
  logic [HDR_WIDTH-1:0]  serdes_rx_hdr;

  // master = block source / sink on the PCS side, slave = the injector
  modport master (
    output serdes_tx_data, serdes_tx_hdr,
    input  serdes_rx_data, serdes_rx_hdr
  );
  modport slave (
    input  serdes_tx_data, serdes_tx_hdr,
    output serdes_rx_data, serdes_rx_hdr
  );
endinterface
`default_nettype wire

// File: rtl/pcs_hdr_err_inject.sv
`default_nettype none
// ============================================================================
// pcs_hdr_err_inject : 1-cycle SERDES loopback that corrupts sync headers
// Rev 1.0
// ============================================================================
module pcs_hdr_err_inject #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst,
  pcs_hdr_err_inject_if.slave  serdes,
  input  logic                 cfg_enable,
  input  logic [1:0]           cfg_mode,
  input  logic [15:0]          cfg_period,
  input  logic [7:0]           cfg_burst_len,
  input  logic [HDR_WIDTH-1:0] cfg_hdr_pattern,
  input  logic                 inject_trigger,
  output logic                 inject_active,
  output logic [15:0]          inject_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  localparam logic [1:0] MODE_OFF      = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;
  localparam logic [1:0] MODE_BURST    = 2'd2;
  localparam logic [1:0] MODE_SINGLE   = 2'd3;

  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [7:0]            rem_q, rem_d;
  logic [1:0]            mode_q, mode_d;
  logic                  trig_q, trig_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [HDR_WIDTH-1:0]  rx_hdr_q, rx_hdr_d;
  logic                  active_q, active_d;
  logic [15:0]           count_q, count_d;

  logic                  run_en;
  logic                  wrap;
  logic                  trig_edge;
  logic                  corrupt;
  logic [15:0]           period_m1;
  logic [7:0]            burst_m1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    corrupt   = 1'b0;
    mode_d    = cfg_mode;
    trig_d    = inject_trigger;

    // A mode change costs one idle cycle so the new mode starts from count 0
    run_en    = cfg_enable && (cfg_mode != MODE_OFF) && (cfg_mode == mode_q);
    period_m1 = cfg_period - 16'd1;
    wrap      = (cfg_period != 16'd0) && (cnt_q >= period_m1);
    trig_edge = inject_trigger && !trig_q;
    burst_m1  = (cfg_burst_len == 8'd0) ? 8'd0 : (cfg_burst_len - 8'd1);

    if (!run_en) begin
      state_d = ST_IDLE;
      cnt_d   = 16'd0;
      rem_d   = 8'd0;
    end else begin
      case (cfg_mode)
        MODE_PERIODIC, MODE_BURST: begin
          if (cfg_period == 16'd0) begin
            state_d = ST_IDLE;
            cnt_d   = 16'd0;
            rem_d   = 8'd0;
          end else begin
            cnt_d = wrap ? 16'd0 : (cnt_q + 16'd1);
            // The wrap block is the first corrupted block; rem counts the rest
            if (wrap) begin
              corrupt = 1'b1;
              if ((cfg_mode == MODE_BURST) && (burst_m1 != 8'd0)) begin
                state_d = ST_BURST;
                rem_d   = burst_m1;
              end else begin
                state_d = ST_COUNT;
                rem_d   = 8'd0;
              end
            end else if (state_q == ST_BURST) begin
              corrupt = 1'b1;
              rem_d   = rem_q - 8'd1;
              state_d = (rem_q == 8'd1) ? ST_COUNT : ST_BURST;
            end else begin
              state_d = ST_COUNT;
            end
          end
        end
        MODE_SINGLE: begin
          cnt_d = 16'd0;
          if (state_q == ST_BURST) begin
            corrupt = 1'b1;
            rem_d   = rem_q - 8'd1;
            state_d = (rem_q == 8'd1) ? ST_IDLE : ST_BURST;
          end else if (trig_edge) begin
            corrupt = 1'b1;
            rem_d   = burst_m1;
            state_d = (burst_m1 == 8'd0) ? ST_IDLE : ST_BURST;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
          rem_d   = 8'd0;
        end
      endcase
    end

    rx_data_d = serdes.serdes_tx_data;
    rx_hdr_d  = corrupt ? cfg_hdr_pattern : serdes.serdes_tx_hdr;
    active_d  = corrupt;
    count_d   = (corrupt && (count_q != 16'hFFFF)) ? (count_q + 16'd1) : count_q;
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      rem_q     <= 8'd0;
      mode_q    <= MODE_OFF;
      trig_q    <= 1'b0;
      rx_data_q <= '0;
      rx_hdr_q  <= '0;
      active_q  <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      mode_q    <= mode_d;
      trig_q    <= trig_d;
      rx_data_q <= rx_data_d;
      rx_hdr_q  <= rx_hdr_d;
      active_q  <= active_d;
      count_q   <= count_d;
    end
  end

  assign serdes.serdes_rx_data = rx_data_q;
  assign serdes.serdes_rx_hdr  = rx_hdr_q;
  assign inject_active         = active_q;
  assign inject_count          = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pcs_hdr_err_inject.sv
`default_nettype none
// ============================================================================
// tb_pcs_hdr_err_inject : directed bench with a per-cycle reference model
// Rev 1.0
// ============================================================================
module tb_pcs_hdr_err_inject;
  localparam int DW = 64;
  localparam int HW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_enable;
  logic [1:0]    cfg_mode;
  logic [15:0]   cfg_period;
  logic [7:0]    cfg_burst_len;
  logic [HW-1:0] cfg_hdr_pattern;
  logic          inject_trigger;
  logic          inject_active;
  logic [15:0]   inject_count;

  always #5 clk = ~clk;

  pcs_hdr_err_inject_if #(.DATA_WIDTH(DW), .HDR_WIDTH(HW)) sif ();

  pcs_hdr_err_inject #(.DATA_WIDTH(DW), .HDR_WIDTH(HW)) dut (
    .rx_clk          (clk),
    .rx_rst          (rst),
    .serdes          (sif.slave),
    .cfg_enable      (cfg_enable),
    .cfg_mode        (cfg_mode),
    .cfg_period      (cfg_period),
    .cfg_burst_len   (cfg_burst_len),
    .cfg_hdr_pattern (cfg_hdr_pattern),
    .inject_trigger  (inject_trigger),
    .inject_active   (inject_active),
    .inject_count    (inject_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: n = blocks since counting began; a wrap is n mod period == period-1;
  // burst corruption covers the eff_len blocks starting at the most recent wrap.
  logic [DW-1:0] exp_data;
  logic [HW-1:0] exp_hdr;
  logic          exp_act;
  int            exp_cnt;
  logic          model_valid = 1'b0;
  int            n, last_wrap, shot_left, p, eff;
  logic [1:0]    prev_mode;
  logic          trig_prev;
  logic          hit;

  always @(posedge clk) begin
    hit = 1'b0;
    eff = (cfg_burst_len == 8'd0) ? 1 : int'(cfg_burst_len);
    p   = int'(cfg_period);
    if (rst) begin
      n = 0; last_wrap = -1000000; shot_left = 0;
      prev_mode = 2'd0; trig_prev = 1'b0;
      exp_data = '0; exp_hdr = '0; exp_act = 1'b0; exp_cnt = 0;
    end else begin
      if (!(cfg_enable && cfg_mode != 2'd0 && cfg_mode == prev_mode)) begin
        n = 0; last_wrap = -1000000; shot_left = 0;
      end else if (cfg_mode == 2'd1 || cfg_mode == 2'd2) begin
        if (p == 0) begin
          n = 0;
        end else begin
          if (n % p == p - 1) last_wrap = n;
          hit = (cfg_mode == 2'd1) ? (last_wrap == n) : ((n - last_wrap) < eff);
          n++;
        end
      end else begin
        if (shot_left > 0) begin
          hit = 1'b1; shot_left--;
        end else if (inject_trigger && !trig_prev) begin
          hit = 1'b1; shot_left = eff - 1;
        end
      end
      prev_mode = cfg_mode;
      trig_prev = inject_trigger;
      exp_data  = sif.serdes_tx_data;
      exp_hdr   = hit ? cfg_hdr_pattern : sif.serdes_tx_hdr;
      exp_act   = hit;
      if (hit && exp_cnt < 65535) exp_cnt++;
    end
    model_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_rx_data", sif.serdes_rx_data, exp_data);
      check("model_rx_hdr", sif.serdes_rx_hdr, exp_hdr);
      check("model_active", inject_active, exp_act);
      check("model_count", inject_count, exp_cnt[15:0]);
    end
  end

  task automatic send(input logic [63:0] d, input logic [1:0] h);
    sif.serdes_tx_data = d;
    sif.serdes_tx_hdr  = h;
    @(posedge clk);
    #1;
  endtask

  task automatic run_trig(input int nblk, input logic [31:0] trig, output logic [31:0] mask);
    mask = '0;
    for (int k = 0; k < nblk; k++) begin
      inject_trigger = trig[k];
      send({32'(k) * 32'h9E37_79B9, 32'hC0DE_0000 | 32'(k)}, (k % 2 == 0) ? 2'b01 : 2'b10);
      mask[k] = inject_active;
    end
    inject_trigger = 1'b0;
  endtask

  task automatic run(input int nblk, output logic [31:0] mask);
    run_trig(nblk, 32'd0, mask);
  endtask

  task automatic restart(input logic [1:0] mode);
    cfg_mode = 2'd0;
    send(64'h1111_2222_3333_4444, 2'b01);
    cfg_mode = mode;
    send(64'h5555_6666_7777_8888, 2'b10);
  endtask

  logic [63:0] pt [6];
  logic [31:0] m;

  initial begin
    rst = 1'b1; cfg_enable = 1'b0; cfg_mode = 2'd0; cfg_period = 16'd0;
    cfg_burst_len = 8'd0; cfg_hdr_pattern = 2'b00; inject_trigger = 1'b0;
    sif.serdes_tx_data = '1; sif.serdes_tx_hdr = 2'b01;
    repeat (3) begin @(posedge clk); #1; end
    check("reset_data", sif.serdes_rx_data, 64'd0);
    check("reset_hdr", sif.serdes_rx_hdr, 2'b00);
    check("reset_active", inject_active, 1'b0);
    check("reset_count", inject_count, 16'd0);
    rst = 1'b0;

    pt = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 64'h5555_5555_5555_5555,
           64'hAAAA_AAAA_AAAA_AAAA, 64'hFEFE_FEFE_FEFE_FEFE, 64'h0707_0707_0707_0707};
    for (int k = 0; k < 6; k++) begin
      send(pt[k], 2'b01);
      check("pt_data", sif.serdes_rx_data, pt[k]);
      check("pt_hdr", sif.serdes_rx_hdr, 2'b01);
    end
    check("pt_count", inject_count, 16'd0);

    cfg_enable = 1'b1; cfg_period = 16'd4; cfg_hdr_pattern = 2'b00;
    restart(2'd1);
    run(16, m);
    check("periodic_mask", m[15:0], 16'h8888);
    check("periodic_count", inject_count, 16'd4);

    cfg_period = 16'd10; cfg_burst_len = 8'd3; cfg_hdr_pattern = 2'b11;
    restart(2'd2);
    run(25, m);
    check("burst3_mask", m[24:0], 25'h0380E00);
    check("burst3_count", inject_count, 16'd10);

    cfg_burst_len = 8'd12;
    restart(2'd2);
    run(30, m);
    check("burst12_mask", m[29:0], 30'h3FFFFE00);
    check("burst12_count", inject_count, 16'd31);

    cfg_burst_len = 8'd0; cfg_hdr_pattern = 2'b10;
    restart(2'd3);
    run_trig(12, 32'h31F, m);
    check("single_len0_mask", m[11:0], 12'h101);
    check("single_len0_count", inject_count, 16'd33);
    cfg_burst_len = 8'd3;
    run_trig(6, 32'h05, m);
    check("single_len3_mask", m[5:0], 6'h07);
    check("single_len3_count", inject_count, 16'd36);

    cfg_period = 16'd10; cfg_burst_len = 8'd5; cfg_hdr_pattern = 2'b00;
    restart(2'd2);
    run(11, m);
    check("abort_en_mask", m[10:0], 11'h600);
    cfg_enable = 1'b0;
    send(64'hDEAD_BEEF_0000_0001, 2'b01);
    check("abort_en_active", inject_active, 1'b0);
    check("abort_en_hdr", sif.serdes_rx_hdr, 2'b01);
    check("abort_en_count", inject_count, 16'd38);
    cfg_enable = 1'b1;

    restart(2'd2);
    run(11, m);
    check("abort_rst_mask", m[10:0], 11'h600);
    rst = 1'b1;
    send(64'hDEAD_BEEF_0000_0002, 2'b01);
    check("rst_mid_active", inject_active, 1'b0);
    check("rst_mid_data", sif.serdes_rx_data, 64'd0);
    check("rst_mid_count", inject_count, 16'd0);
    send(64'hDEAD_BEEF_0000_0003, 2'b01);
    rst = 1'b0;
    send(64'hDEAD_BEEF_0000_0004, 2'b10);
    check("post_rst_active", inject_active, 1'b0);
    check("post_rst_hdr", sif.serdes_rx_hdr, 2'b10);
    check("post_rst_data", sif.serdes_rx_data, 64'hDEAD_BEEF_0000_0004);
    check("post_rst_count", inject_count, 16'd0);

    cfg_period = 16'd1; cfg_hdr_pattern = 2'b11;
    restart(2'd1);
    for (int k = 0; k < 70000; k++) send(64'(k), 2'b01);
    check("sat_count", inject_count, 16'hFFFF);
    repeat (5) send(64'h0123_4567_89AB_CDEF, 2'b10);
    check("sat_hold", inject_count, 16'hFFFF);
    check("sat_active", inject_active, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
